// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcode encodings and default width for the ALU
package alu_pkg;

  // Default datapath width; arithmetic wraps modulo 2^DEFAULT_WIDTH.
  localparam int unsigned DEFAULT_WIDTH = 32;

  // Operation select encodings on aluc.
  localparam logic [2:0] ALUC_ADD = 3'd0;
  localparam logic [2:0] ALUC_SUB = 3'd1;
  localparam logic [2:0] ALUC_AND = 3'd2;
  localparam logic [2:0] ALUC_OR  = 3'd3;
  localparam logic [2:0] ALUC_XOR = 3'd4;
  localparam logic [2:0] ALUC_NOR = 3'd5;
  localparam logic [2:0] ALUC_SLT = 3'd6;
  localparam logic [2:0] ALUC_SLL = 3'd7;

endpackage

// File: rtl/alu_addsub.sv
// rtl/alu_addsub.sv - shared adder/subtractor with signed overflow detect
module alu_addsub #(
  parameter int unsigned WIDTH = alu_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] cin_ext;

  // Subtraction is a + ~b + 1; carry out is dropped so results wrap.
  // Overflow: operands (as seen by the adder) share a sign that the sum lacks.
  always_comb begin
    b_eff   = b ^ {WIDTH{sub}};
    cin_ext = {{(WIDTH-1){1'b0}}, sub};
    sum     = a + b_eff + cin_ext;
    ovf     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/alu_core.sv
// rtl/alu_core.sv - 32-bit registered ALU; ALU_SHIFT_EN enables the aluc=7 left shift
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       aluc,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero,
  output logic             over
);

  logic [WIDTH-1:0] alu_out_d, alu_out_q;
  logic             zero_d, zero_q;
  logic             over_d, over_q;

  logic [WIDTH-1:0] addsub_sum;
  logic             addsub_ovf;
  logic             is_sub;

  // One adder serves both ADD and SUB; SLT uses its own signed compare.
  assign is_sub = (aluc == ALUC_SUB);

  alu_addsub #(
    .WIDTH (WIDTH)
  ) u_addsub (
    .a   (a),
    .b   (b),
    .sub (is_sub),
    .sum (addsub_sum),
    .ovf (addsub_ovf)
  );

`ifdef ALU_SHIFT_EN
  localparam int unsigned SHAMT_W = $clog2(WIDTH);
  logic [WIDTH-1:0] shl_res;
  assign shl_res = a << b[SHAMT_W-1:0];
`endif

  // Opcode mux: next result, its zero flag, and overflow for ADD/SUB only.
  always_comb begin
    alu_out_d = '0;
    over_d    = 1'b0;
    case (aluc)
      ALUC_ADD: begin
        alu_out_d = addsub_sum;
        over_d    = addsub_ovf;
      end
      ALUC_SUB: begin
        alu_out_d = addsub_sum;
        over_d    = addsub_ovf;
      end
      ALUC_AND: alu_out_d = a & b;
      ALUC_OR:  alu_out_d = a | b;
      ALUC_XOR: alu_out_d = a ^ b;
      ALUC_NOR: alu_out_d = ~(a | b);
      ALUC_SLT: alu_out_d = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_SHIFT_EN
      ALUC_SLL: alu_out_d = shl_res;
`else
      ALUC_SLL: alu_out_d = '0;
`endif
      default:  alu_out_d = '0;
    endcase
    zero_d = (alu_out_d == '0);
  end

  // Output registers; reset forces a zero result and wins over any op.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out_q <= '0;
      zero_q    <= 1'b1;
      over_q    <= 1'b0;
    end else begin
      alu_out_q <= alu_out_d;
      zero_q    <= zero_d;
      over_q    <= over_d;
    end
  end

  assign alu_out = alu_out_q;
  assign zero    = zero_q;
  assign over    = over_q;

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - directed vector bench for alu_core
module tb_alu_core;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  aluc;
  logic [31:0] alu_out;
  logic        zero;
  logic        over;

  int n_cmp;
  int n_fail;

  typedef struct {
    string       name;
    logic [2:0]  aluc;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] out;
    logic        zero;
    logic        over;
  } vec_t;

  vec_t vecs[$];

  alu_core dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .aluc    (aluc),
    .alu_out (alu_out),
    .zero    (zero),
    .over    (over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [31:0] e_out, input logic e_zero, input logic e_over);
    check({name, ".out"}, alu_out, e_out);
    check({name, ".zero"}, {31'b0, zero}, {31'b0, e_zero});
    check({name, ".over"}, {31'b0, over}, {31'b0, e_over});
  endtask

  task automatic add_vec(input string n, input logic [2:0] op, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] eo, input logic ez, input logic ev);
    vec_t v;
    v.name = n; v.aluc = op; v.a = va; v.b = vb;
    v.out = eo; v.zero = ez; v.over = ev;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] va, input logic [31:0] vb);
    aluc = op;
    a    = va;
    b    = vb;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;

    add_vec("add_ovf",     3'd0, 32'h7fffffff, 32'h7fffffff, 32'hfffffffe, 1'b0, 1'b1);
    add_vec("add_wrap0",   3'd0, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
    add_vec("add_negovf",  3'd0, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1);
    add_vec("add_plain",   3'd0, 32'h00001234, 32'h00000111, 32'h00001345, 1'b0, 1'b0);
    add_vec("sub_ovf",     3'd1, 32'h01ffffff, 32'h80000000, 32'h81ffffff, 1'b0, 1'b1);
    add_vec("sub_eq",      3'd1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0);
    add_vec("sub_minovf",  3'd1, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b0, 1'b1);
    add_vec("sub_neg",     3'd1, 32'h00000001, 32'h00000002, 32'hffffffff, 1'b0, 1'b0);
    add_vec("and",         3'd2, 32'h0555ffff, 32'h0aaabbbb, 32'h0000bbbb, 1'b0, 1'b0);
    add_vec("or",          3'd3, 32'h0555ffff, 32'h0aaabbbb, 32'h0fffffff, 1'b0, 1'b0);
    add_vec("xor",         3'd4, 32'h0555ffff, 32'h0aaabbbb, 32'h0fff4444, 1'b0, 1'b0);
    add_vec("nor",         3'd5, 32'h0555ffff, 32'h0aaabbbb, 32'hf0000000, 1'b0, 1'b0);
    add_vec("and_zero",    3'd2, 32'h55555555, 32'haaaaaaaa, 32'h00000000, 1'b1, 1'b0);
    add_vec("slt_neg",     3'd6, 32'h80000000, 32'h00000001, 32'h00000001, 1'b0, 1'b0);
    add_vec("slt_pos",     3'd6, 32'h00000001, 32'h80000000, 32'h00000000, 1'b1, 1'b0);
    add_vec("slt_subovf",  3'd6, 32'h7fffffff, 32'h80000000, 32'h00000000, 1'b1, 1'b0);
    add_vec("slt_subovf2", 3'd6, 32'h80000000, 32'h7fffffff, 32'h00000001, 1'b0, 1'b0);
    add_vec("slt_eq",      3'd6, 32'hfffffff0, 32'hfffffff0, 32'h00000000, 1'b1, 1'b0);
`ifdef ALU_SHIFT_EN
    add_vec("sll_31",      3'd7, 32'h00000001, 32'h0000001f, 32'h80000000, 1'b0, 1'b0);
    add_vec("sll_4_mask",  3'd7, 32'h00000003, 32'h00000024, 32'h00000030, 1'b0, 1'b0);
    add_vec("sll_out",     3'd7, 32'h00000002, 32'h0000001f, 32'h00000000, 1'b1, 1'b0);
`else
    add_vec("sll_31",      3'd7, 32'h00000001, 32'h0000001f, 32'h00000000, 1'b1, 1'b0);
    add_vec("sll_4_mask",  3'd7, 32'h00000003, 32'h00000024, 32'h00000000, 1'b1, 1'b0);
    add_vec("sll_out",     3'd7, 32'hffffffff, 32'h00000001, 32'h00000000, 1'b1, 1'b0);
`endif

    // Reset state after one edge with rst high, an op already on the inputs.
    rst = 1'b1;
    drive(3'd0, 32'h00000005, 32'h00000006);
    @(posedge clk);
    #1;
    check_all("reset", 32'h00000000, 1'b1, 1'b0);

    // Outputs are registered: new inputs must not show before the edge.
    rst = 1'b0;
    drive(3'd0, 32'h7fffffff, 32'h7fffffff);
    #2;
    check_all("latency_hold", 32'h00000000, 1'b1, 1'b0);

    // Back-to-back table: one op per cycle, checked one cycle later.
    foreach (vecs[i]) begin
      drive(vecs[i].aluc, vecs[i].a, vecs[i].b);
      @(posedge clk);
      #1;
      check_all(vecs[i].name, vecs[i].out, vecs[i].zero, vecs[i].over);
    end

    // Reset asserted alongside an overflowing ADD: reset values win.
    drive(3'd0, 32'h7fffffff, 32'h7fffffff);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_all("rst_vs_add", 32'h00000000, 1'b1, 1'b0);

    // Reset alongside a NOR that would give all ones.
    drive(3'd5, 32'h00000000, 32'h00000000);
    @(posedge clk);
    #1;
    check_all("rst_vs_nor", 32'h00000000, 1'b1, 1'b0);

    // Release reset with the same NOR held: result appears next edge.
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_all("post_rst_nor", 32'hffffffff, 1'b0, 1'b0);

    // Overflow flag must clear when the following op is not ADD/SUB.
    drive(3'd1, 32'h80000000, 32'h00000001);
    @(posedge clk);
    #1;
    check_all("ovf_set", 32'h7fffffff, 1'b0, 1'b1);
    drive(3'd3, 32'h80000000, 32'h00000001);
    @(posedge clk);
    #1;
    check_all("ovf_clear", 32'h80000001, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
